mac_operand_loader: RTL and testbench

//  Writer side of the MAC operand memories: accepts a byte stream (valid/ready)
//  and fills the three operand BRAMs a, b, c in order (DEPTH bytes each).

---
 rtl/mac_pkg.sv | 17 +
 rtl/mac_operand_loader_if.sv | 28 ++
 rtl/mac_operand_loader.sv | 84 ++++++++
 tb/tb_mac_operand_loader.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared definitions for the MAC operand path: operand/address widths and the
// loader state encoding.
package mac_pkg;
   localparam int DATA_W  = 8;
   localparam int DEPTH   = 10;
   localparam int ADDR_W  = 4;
   localparam int MAC_W   = 17;

   typedef enum logic [2:0] {
      IDLE,
      LOAD_A,
      LOAD_B,
      LOAD_C,
      DONE,
      FLUSH
   } ld_state_e;
endpackage

// File: rtl/mac_operand_loader_if.sv
// Byte-stream input and shared BRAM write port of the operand loader.
interface mac_operand_loader_if;
   import mac_pkg::*;

   logic              start;
   logic              s_valid;
   logic [DATA_W-1:0] s_data;
   logic              s_last;
   logic              s_ready;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              we_a;
   logic              we_b;
   logic              we_c;
   logic              busy;
   logic              done;
   logic              frame_err;

   modport master (
      output start, s_valid, s_data, s_last,
      input  s_ready, wr_addr, wr_data, we_a, we_b, we_c, busy, done, frame_err
   );

   modport slave (
      input  start, s_valid, s_data, s_last,
      output s_ready, wr_addr, wr_data, we_a, we_b, we_c, busy, done, frame_err
   );
endinterface

// File: rtl/mac_operand_loader.sv
// Fills operand BRAMs a, b, c (DEPTH bytes each) from a byte stream, checks the
// s_last frame boundary and pulses done when all three arrays are written.
module mac_operand_loader
   import mac_pkg::*;
(
   input  logic                 clk,
   input  logic                 reset,
   mac_operand_loader_if.slave  bus
);

   ld_state_e         state;
   logic [ADDR_W-1:0] cnt;
   logic              hs;
   logic              last_elem;

   assign hs        = bus.s_valid & bus.s_ready;
   assign last_elem = (cnt == ADDR_W'(DEPTH - 1));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state         <= IDLE;
         cnt           <= '0;
         bus.s_ready   <= 1'b0;
         bus.wr_addr   <= '0;
         bus.wr_data   <= '0;
         bus.we_a      <= 1'b0;
         bus.we_b      <= 1'b0;
         bus.we_c      <= 1'b0;
         bus.busy      <= 1'b0;
         bus.done      <= 1'b0;
         bus.frame_err <= 1'b0;
      end else begin
         bus.we_a      <= 1'b0;
         bus.we_b      <= 1'b0;
         bus.we_c      <= 1'b0;
         bus.done      <= 1'b0;
         bus.frame_err <= 1'b0;
         case (state)
            IDLE: if (bus.start) begin
               state       <= LOAD_A;
               cnt         <= '0;
               bus.busy    <= 1'b1;
               bus.s_ready <= 1'b1;
            end
            LOAD_A, LOAD_B, LOAD_C: if (hs) begin
               bus.wr_addr <= cnt;
               bus.wr_data <= bus.s_data;
               bus.we_a    <= (state == LOAD_A);
               bus.we_b    <= (state == LOAD_B);
               bus.we_c    <= (state == LOAD_C);
               cnt         <= last_elem ? '0 : cnt + 1'b1;
               // Final byte of the frame: s_last decides between DONE and FLUSH
               if (state == LOAD_C && last_elem) begin
                  if (bus.s_last) begin
                     state       <= DONE;
                     bus.done    <= 1'b1;
                     bus.busy    <= 1'b0;
                     bus.s_ready <= 1'b0;
                  end else begin
                     state         <= FLUSH;
                     bus.frame_err <= 1'b1;
                  end
               end else if (bus.s_last) begin
                  state         <= IDLE;
                  bus.frame_err <= 1'b1;
                  bus.busy      <= 1'b0;
                  bus.s_ready   <= 1'b0;
               end else if (last_elem) begin
                  state <= (state == LOAD_A) ? LOAD_B : LOAD_C;
               end
            end
            DONE: state <= IDLE;
            // Overlong frame: swallow bytes until the sender closes it
            FLUSH: if (hs && bus.s_last) begin
               state       <= IDLE;
               bus.busy    <= 1'b0;
               bus.s_ready <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mac_operand_loader.sv
// Randomized bench for mac_operand_loader against a frame-level write model.
module tb_mac_operand_loader;
   import mac_pkg::*;

   typedef struct {
      int arr;
      int addr;
      int data;
   } wr_t;

   logic clk;
   logic reset;
   mac_operand_loader_if bus();

   mac_operand_loader dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int  n_chk;
   int  n_pass;
   int  n_done;
   int  n_ferr;
   wr_t obs_q[$];
   wr_t exp_q[$];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp)
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      else
         n_pass++;
   endtask

   // Collect BRAM writes and pulses, checking per-cycle invariants.
   always @(negedge clk) begin
      if (reset) begin
         if (bus.we_a || bus.we_b || bus.we_c) begin
            chk("we_onehot", int'(bus.we_a) + int'(bus.we_b) + int'(bus.we_c), 1);
            obs_q.push_back('{arr: bus.we_a ? 0 : bus.we_b ? 1 : 2,
                              addr: int'(bus.wr_addr), data: int'(bus.wr_data)});
         end
         if (bus.done) begin
            n_done++;
            chk("done_with_we_c", bus.we_c, 1'b1);
            chk("busy_drop_at_done", bus.busy, 1'b0);
         end
         if (bus.frame_err) begin
            n_ferr++;
            chk("ferr_with_write", bus.we_a | bus.we_b | bus.we_c, 1'b1);
         end
      end
   end

   task automatic check_idle_outputs(input string tag);
      chk({tag, "_s_ready"}, bus.s_ready, 1'b0);
      chk({tag, "_we"}, {bus.we_a, bus.we_b, bus.we_c}, 3'b000);
      chk({tag, "_busy"}, bus.busy, 1'b0);
      chk({tag, "_done"}, bus.done, 1'b0);
      chk({tag, "_ferr"}, bus.frame_err, 1'b0);
      chk({tag, "_wr_addr"}, bus.wr_addr, '0);
      chk({tag, "_wr_data"}, bus.wr_data, '0);
   endtask

   // One frame: start, nbytes bytes with s_last on byte last_pos (0 = never).
   task automatic run_frame(input int nbytes, input int last_pos, input bit gaps,
                            input bit rnd_data, input bit start_mid);
      logic [DATA_W-1:0] d[$];
      bit exp_done;
      for (int i = 1; i <= nbytes; i++)
         d.push_back(rnd_data ? DATA_W'($urandom) : DATA_W'(i));
      // Model: bytes 1..3*DEPTH land in a,b,c in order; anything later is dropped
      exp_q.delete();
      for (int i = 1; i <= nbytes && i <= 3 * DEPTH; i++)
         exp_q.push_back('{arr: (i - 1) / DEPTH, addr: (i - 1) % DEPTH, data: int'(d[i-1])});
      exp_done = (nbytes == 3 * DEPTH) && (last_pos == 3 * DEPTH);
      obs_q.delete();
      n_done = 0;
      n_ferr = 0;

      @(negedge clk);
      chk("ready_before_start", bus.s_ready, 1'b0);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      chk("busy_after_start", bus.busy, 1'b1);
      for (int i = 1; i <= nbytes; i++) begin
         if (gaps) begin
            bus.s_valid = 1'b0;
            repeat ($urandom_range(0, 3)) @(negedge clk);
         end
         bus.s_valid = 1'b1;
         bus.s_data  = d[i-1];
         bus.s_last  = (i == last_pos);
         bus.start   = start_mid && (i >= DEPTH + 1) && (i <= 2 * DEPTH);
         if (!bus.s_ready) chk("ready_in_frame", bus.s_ready, 1'b1);
         @(negedge clk);
      end
      bus.s_valid = 1'b0;
      bus.s_last  = 1'b0;
      bus.start   = 1'b0;
      repeat (3) @(negedge clk);

      chk("wr_count", obs_q.size(), exp_q.size());
      for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
         chk($sformatf("wr%0d_arr", k), obs_q[k].arr, exp_q[k].arr);
         chk($sformatf("wr%0d_addr", k), obs_q[k].addr, exp_q[k].addr);
         chk($sformatf("wr%0d_data", k), obs_q[k].data, exp_q[k].data);
      end
      chk("done_count", n_done, exp_done ? 1 : 0);
      chk("ferr_count", n_ferr, exp_done ? 0 : 1);
      chk("busy_after_frame", bus.busy, 1'b0);
      chk("ready_after_frame", bus.s_ready, 1'b0);
   endtask

   initial begin
      n_chk = 0;
      n_pass = 0;
      n_done = 0;
      n_ferr = 0;
      reset = 1'b0;
      bus.start = 1'b0;
      bus.s_valid = 1'b0;
      bus.s_data = '0;
      bus.s_last = 1'b0;
      #3;
      check_idle_outputs("reset");
      repeat (2) @(negedge clk);
      reset = 1'b1;

      // start-free idle: nothing moves
      bus.s_valid = 1'b1;
      repeat (3) @(negedge clk);
      bus.s_valid = 1'b0;
      chk("idle_no_ready", bus.s_ready, 1'b0);
      chk("idle_no_write", obs_q.size(), 0);

      run_frame(3 * DEPTH, 3 * DEPTH, 1'b0, 1'b0, 1'b0);   // nominal 01..1E
      run_frame(3 * DEPTH, 3 * DEPTH, 1'b1, 1'b1, 1'b0);   // random stalls
      run_frame(12, 12, 1'b1, 1'b1, 1'b0);                 // early s_last
      run_frame(33, 33, 1'b0, 1'b1, 1'b0);                 // missing s_last
      run_frame(3 * DEPTH, 3 * DEPTH, 1'b1, 1'b1, 1'b1);   // start during LOAD_B

      // Reset mid-load after byte 15
      @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      for (int i = 1; i <= 15; i++) begin
         bus.s_valid = 1'b1;
         bus.s_data  = DATA_W'($urandom);
         @(negedge clk);
      end
      bus.s_valid = 1'b0;
      #2 reset = 1'b0;
      #1;
      check_idle_outputs("midreset");
      repeat (2) @(negedge clk);
      reset = 1'b1;
      run_frame(3 * DEPTH, 3 * DEPTH, 1'b1, 1'b1, 1'b0);

      // A few more random frames of mixed shape
      for (int f = 0; f < 4; f++) begin
         case ($urandom_range(0, 2))
            0: run_frame(3 * DEPTH, 3 * DEPTH, 1'b1, 1'b1, 1'b0);
            1: begin
               int n;
               n = $urandom_range(1, 3 * DEPTH - 1);
               run_frame(n, n, 1'b1, 1'b1, 1'b0);
            end
            default: begin
               int n;
               n = $urandom_range(3 * DEPTH + 1, 3 * DEPTH + 6);
               run_frame(n, n, 1'b1, 1'b1, 1'b0);
            end
         endcase
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
